div_burst_ctrl: RTL and testbench
=================================

Name: div_burst_ctrl

Overview:
- Programmable carrier/subcarrier clock-divider controller for the RFID front end.
- Generates a glitch-free divided clock `clk_out` with a runtime-selectable half-period.
- Sequences bursts of N output cycles, or runs continuously, under start/stop control.
- Provides a rising-edge strobe and a completed-cycle count so the modulator datapath can align to the divided clock.

Parameters:
- DIV_W, 8: width of the half-period config.
- CNT_W, 16: width of the burst-length config and of the cycle counter.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- cfg_half_period_in  input  DIV_W  clk_in cycles per output half-period H; 0 is treated as 1.
- cfg_cycles_in  input  CNT_W  output cycles per burst N; 0 means continuous until stopped.
- start_in  input  1  single-cycle start request.
- stop_in  input  1  single-cycle stop request.
- clk_out  output  1  divided clock, registered.
- edge_out  output  1  one-cycle pulse in each cycle where clk_out has just risen.
- busy_out  output  1  high while a burst is active (RUN or STOPPING).
- done_out  output  1  one-cycle pulse at burst termination.
- cycle_count_out  output  CNT_W  completed output cycles in the current or last burst.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; clk_out, edge_out, busy_out, done_out all 0; cycle_count_out=0; half counter hc=0.
  - Applies from the cycle after rst_in is sampled, including mid-burst. No done pulse is issued on reset.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - clk_out=0.
  - start_in sampled high: latch H (0 becomes 1) and N; clear cycle_count and hc; go to RUN.
  - Next cycle: clk_out=1, edge_out=1, busy_out=1. Start-to-first-rise latency is 1 cycle.
  - stop_in in IDLE is ignored. start_in together with stop_in in IDLE: start wins, stop is dropped.
- RUN / STOPPING waveform:
  - hc counts 0..H-1 within each phase.
  - At hc==H-1: reset hc to 0 and end the phase.
  - Each phase lasts exactly H cycles; period is 2H. The high phase comes first.
  - End of high phase: clk_out falls.
  - End of low phase: one cycle is complete; cycle_count increments and is visible the next cycle. Then:
    - RUN with N!=0 and incremented count==N: go to IDLE.
    - STOPPING: go to IDLE.
    - Otherwise: clk_out rises and edge_out pulses.
  - On the transition to IDLE: clk_out stays 0, busy_out falls, and done_out pulses, all in the same cycle.
  - No truncated high or low phase is ever produced. Restarting from IDLE always follows a full low phase.
- stop_in in RUN: go to STOPPING. The current cycle finishes through its full low phase, then the block goes to IDLE.
  - Stop arriving during the terminal cycle of an N burst: identical result, single done pulse.
  - Repeated stop_in in STOPPING: no effect.
- start_in while busy: ignored. Config inputs are sampled only at an accepted start; mid-burst changes have no effect.
- Continuous mode (N=0): cycle_count wraps from 2^CNT_W-1 to 0 and never terminates on its own.
- cycle_count_out holds its final value in IDLE until the next accepted start clears it.
- H=1: clk_out toggles every clk_in cycle, period 2.
- Bursts allow N up to 2^CNT_W-1 cycles.

Test Plan:
- Reset, then H=2, N=2, start at cycle 0 -> clk_out=1 in cycles 1-2, 0 in 3-4, 1 in 5-6, 0 in 7-8; edge_out pulses at cycles 1 and 5; cycle_count_out=1 at cycle 5 and 2 at cycle 9; done_out and busy_out falling at cycle 9.
- H=0, N=3 -> clk_out toggles every cycle (period 2); 3 rising edges; done 6 cycles after first rise.
- H=4, N=0, stop_in pulsed in the 2nd cycle of a high phase -> high phase completes (4 cycles), full 4-cycle low phase follows, then done; no further edge_out.
- H=3, N=5, start_in re-pulsed mid-burst and cfg changed to H=1 mid-burst -> ignored; exactly 5 cycles of period 6.
- rst_in asserted mid-high-phase -> next cycle all outputs 0, no done pulse; a subsequent start works normally.
- start_in and stop_in together in IDLE -> burst starts. stop_in in the terminal cycle of N=1, H=1 -> exactly one done pulse, cycle_count_out=1.

Source files
------------

// File: rtl/div_burst_ctrl.sv
// Burst-sequenced programmable clock divider for the RFID front end.
// Emits a registered divided clock plus rise strobe, busy/done and cycle count.
module div_burst_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [DIV_W-1:0] cfg_half_period_in,
    input  logic [CNT_W-1:0] cfg_cycles_in,
    input  logic             start_in,
    input  logic             stop_in,
    output logic             clk_out,
    output logic             edge_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [CNT_W-1:0] cycle_count_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] hc_q, hc_d;
    logic [DIV_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             edge_q, edge_d;
    logic             done_q, done_d;

    logic             phase_end;
    logic [CNT_W-1:0] cnt_inc;
    logic             stop_pend;

    assign phase_end = (hc_q == h_q - DIV_W'(1));
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign stop_pend = (state_q == STOPPING) || stop_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            hc_q    <= '0;
            h_q     <= DIV_W'(1);
            n_q     <= '0;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            edge_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            h_q     <= h_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            edge_q  <= edge_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        h_d     = h_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        edge_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                clk_d = 1'b0;
                if (start_in) begin
                    h_d     = (cfg_half_period_in == '0) ? DIV_W'(1)
                                                         : cfg_half_period_in;
                    n_d     = cfg_cycles_in;
                    cnt_d   = '0;
                    hc_d    = '0;
                    clk_d   = 1'b1;
                    edge_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN, STOPPING: begin
                if (stop_in) state_d = STOPPING;
                if (!phase_end) begin
                    hc_d = hc_q + DIV_W'(1);
                end else begin
                    hc_d = '0;
                    if (clk_q) begin
                        clk_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                        // Terminal cycle: stop and count limit share one exit.
                        if (stop_pend || (n_q != '0 && cnt_inc == n_q)) begin
                            clk_d   = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            clk_d  = 1'b1;
                            edge_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clk_out         = clk_q;
    assign edge_out        = edge_q;
    assign busy_out        = (state_q != IDLE);
    assign done_out        = done_q;
    assign cycle_count_out = cnt_q;

endmodule

// File: tb/tb_div_burst_ctrl.sv
// Scoreboard bench for div_burst_ctrl: expected edge/done events are queued
// by the stimulus and matched by a monitor on every strobe.
module tb_div_burst_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  cfg_h;
    logic [15:0] cfg_n;
    logic        start, stop;
    logic        clk_o, edge_o, busy_o, done_o;
    logic [15:0] cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic        is_done;
        int          cyc;
        logic [15:0] cnt;
    } ev_t;

    ev_t q[$];

    div_burst_ctrl #(.DIV_W(8), .CNT_W(16)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .cfg_half_period_in(cfg_h),
        .cfg_cycles_in(cfg_n),
        .start_in(start),
        .stop_in(stop),
        .clk_out(clk_o),
        .edge_out(edge_o),
        .busy_out(busy_o),
        .done_out(done_o),
        .cycle_count_out(cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (edge_o || done_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d edge=%0b done=%0b cnt=%0d required none",
                         cyc, edge_o, done_o, cnt_o);
            end else begin
                ev_t e;
                e = q.pop_front();
                if ((edge_o && done_o) || done_o != e.is_done ||
                    cyc != e.cyc || cnt_o != e.cnt) begin
                    errors++;
                    $display("FAIL event actual done=%0b edge=%0b cyc=%0d cnt=%0d required done=%0b cyc=%0d cnt=%0d",
                             done_o, edge_o, cyc, cnt_o, e.is_done, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic ev(bit d, int c, int n);
        q.push_back('{is_done: d, cyc: c, cnt: 16'(n)});
    endtask

    task automatic step();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic go(input logic [7:0] h, input logic [15:0] n, output int t0);
        cfg_h = h;
        cfg_n = n;
        start = 1'b1;
        t0 = cyc;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 200 && q.size() > 0; i++) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0", name, q.size());
            q.delete();
        end
        step();
        step();
    endtask

    task automatic wait_to(int c);
        while (cyc < c) step();
    endtask

    initial begin
        int t0;
        logic [8:0] clk_pat;
        logic [8:0] busy_pat;
        clk_pat  = 9'b000110011;
        busy_pat = 9'b011111111;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_h = 8'd0; cfg_n = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_clk", 32'(clk_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_cnt", 32'(cnt_o), 0);
        rst = 1'b0;
        step();

        // H=2 N=2 with per-cycle waveform
        go(8'd2, 16'd2, t0);
        ev(0, t0 + 1, 0); ev(0, t0 + 5, 1); ev(1, t0 + 9, 2);
        step();
        for (int i = 0; i < 9; i++) begin
            chk("t1_clk", 32'(clk_o), 32'(clk_pat[i]));
            chk("t1_busy", 32'(busy_o), 32'(busy_pat[i]));
            step();
        end
        drain("t1");

        // H=0 treated as 1, N=3
        go(8'd0, 16'd3, t0);
        ev(0, t0 + 1, 0); ev(0, t0 + 3, 1); ev(0, t0 + 5, 2); ev(1, t0 + 7, 3);
        step();
        chk("t2_clk_hi", 32'(clk_o), 1);
        step();
        chk("t2_clk_lo", 32'(clk_o), 0);
        drain("t2");

        // H=4 continuous, stop in 2nd high cycle
        go(8'd4, 16'd0, t0);
        ev(0, t0 + 1, 0); ev(1, t0 + 9, 1);
        step();
        step();
        stop = 1'b1;
        wait_to(t0 + 4);
        chk("t3_high_done", 32'(clk_o), 1);
        wait_to(t0 + 8);
        chk("t3_low", 32'(clk_o), 0);
        chk("t3_busy_stop", 32'(busy_o), 1);
        step();
        chk("t3_busy_end", 32'(busy_o), 0);
        drain("t3");

        // H=3 N=5, mid-burst start and cfg change ignored
        go(8'd3, 16'd5, t0);
        for (int k = 0; k < 5; k++) ev(0, t0 + 1 + 6 * k, k);
        ev(1, t0 + 31, 5);
        step();
        wait_to(t0 + 8);
        cfg_h = 8'd1; cfg_n = 16'd1; start = 1'b1;
        step();
        drain("t4");
        chk("t4_hold_cnt", 32'(cnt_o), 5);

        // reset mid high phase
        go(8'd5, 16'd0, t0);
        ev(0, t0 + 1, 0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("t5_clk", 32'(clk_o), 0);
        chk("t5_edge", 32'(edge_o), 0);
        chk("t5_busy", 32'(busy_o), 0);
        chk("t5_done", 32'(done_o), 0);
        chk("t5_cnt", 32'(cnt_o), 0);
        rst = 1'b0;
        step();
        go(8'd1, 16'd2, t0);
        ev(0, t0 + 1, 0); ev(0, t0 + 3, 1); ev(1, t0 + 5, 2);
        step();
        drain("t5");

        // start and stop together in IDLE: start wins
        go(8'd2, 16'd1, t0);
        stop = 1'b1;
        ev(0, t0 + 1, 0); ev(1, t0 + 5, 1);
        step();
        chk("t6_busy", 32'(busy_o), 1);
        drain("t6");

        // stop in terminal low cycle of N=1 H=1
        go(8'd1, 16'd1, t0);
        ev(0, t0 + 1, 0); ev(1, t0 + 3, 1);
        step();
        step();
        stop = 1'b1;
        step();
        drain("t7");
        chk("t7_cnt", 32'(cnt_o), 1);

        // stop in the high cycle of N=1 H=1
        go(8'd1, 16'd1, t0);
        ev(0, t0 + 1, 0); ev(1, t0 + 3, 1);
        step();
        stop = 1'b1;
        step();
        drain("t8");
        repeat (4) step();
        chk("t8_hold_cnt", 32'(cnt_o), 1);
        chk("t8_idle_clk", 32'(clk_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
